// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encoding,
// move-from-HI/LO codes, iteration count and a small magnitude helper.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_e;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the
// resulting quotient bit into the low end of the quotient word.
module muldiv_divstep (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [31:0] diff;

    // Compare/subtract; the shifted remainder needs 33 bits because the
    // divisor magnitude can be as large as 2^31.
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted[31:0] - div_i;
        if (shifted >= {1'b0, div_i}) begin
            rem_o = diff;
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on start, processed unsigned in MUL or
// DIV, then signs are applied in FIX where HI/LO are written.
// Build option: define MULDIV_FAST_MUL_EN to compute the multiply in a single
// MUL cycle instead of 32 shift-add iterations; divide is iterative always.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        multE,
    input  logic        divE,
    input  logic [1:0]  mfE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    output logic        busyE,
    output logic        stallE,
    output logic [31:0] mfResultE,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic        divZeroE
);

    // acc holds {partial product high, multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        opnd_q, opnd_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               op_div_q, op_div_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               divzero_q, divzero_d;

    logic               last_iter;
    logic               sign_diff;
    logic [31:0]        div_rem;
    logic [31:0]        div_quo;
    logic [63:0]        mul_next;
    logic [63:0]        prod_signed;
    logic [31:0]        quo_signed;
    logic [31:0]        rem_signed;

    muldiv_divstep u_divstep (
        .rem_i (acc_q[63:32]),
        .quo_i (acc_q[31:0]),
        .div_i (opnd_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

`ifdef MULDIV_FAST_MUL_EN
    // Full 64-bit magnitude product in one step.
    always_comb begin
        mul_next = {32'd0, acc_q[31:0]} * {32'd0, opnd_q};
    end
`else
    logic [32:0] mul_sum;

    // One shift-add step: add the multiplicand when the multiplier LSB is
    // set, then shift the whole accumulator right by one.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end
`endif

    // Sign fix-up of the unsigned results.
    always_comb begin
        last_iter   = (cnt_q == CNT_W'(MULDIV_ITER - 1));
        sign_diff   = sign_a_q ^ sign_b_q;
        prod_signed = sign_diff ? (64'd0 - acc_q) : acc_q;
        quo_signed  = sign_diff ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_signed  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state and datapath update for the IDLE/MUL/DIV/FIX sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        op_div_d  = op_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (multE || divE) begin
                    sign_a_d = srcAE[31];
                    sign_b_d = srcBE[31];
                    acc_d    = {32'd0, abs32(srcAE)};
                    opnd_d   = abs32(srcBE);
                    cnt_d    = '0;
                    op_div_d = !multE;
                    state_d  = multE ? MUL : DIV;
                end
            end
            MUL: begin
                acc_d = mul_next;
`ifdef MULDIV_FAST_MUL_EN
                state_d = FIX;
`else
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = FIX;
                end
`endif
            end
            DIV: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d   = FIX;
                    divzero_d = (opnd_q == 32'd0);
                end
            end
            FIX: begin
                if (op_div_q) begin
                    // With a zero divisor every step subtracts nothing, so the
                    // remainder ends up equal to the dividend magnitude and
                    // rem_signed reproduces the original dividend for HI.
                    lo_d = (opnd_q == 32'd0) ? 32'hFFFF_FFFF : quo_signed;
                    hi_d = rem_signed;
                end else begin
                    hi_d = prod_signed[63:32];
                    lo_d = prod_signed[31:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            op_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            op_div_q  <= op_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    // Status, stall request and move-from-HI/LO read port.
    always_comb begin
        busyE    = (state_q != IDLE);
        stallE   = busyE && (multE || divE || (mfE != MF_NONE));
        hiE      = hi_q;
        loE      = lo_q;
        divZeroE = divzero_q;
        case (mfE)
            MF_HI:   mfResultE = hi_q;
            MF_LO:   mfResultE = lo_q;
            default: mfResultE = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus randomized MULT/DIV,
// checked against a signed 64-bit arithmetic reference model.
module tb_muldiv_unit;

    // Entry layout: {latency[7:0], divzero_pulses[1:0], hi[31:0], lo[31:0]}
    localparam int EXP_W = 74;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        multE = 1'b0;
    logic        divE = 1'b0;
    logic [1:0]  mfE = 2'b00;
    logic [31:0] srcAE = 32'd0;
    logic [31:0] srcBE = 32'd0;
    logic        busyE;
    logic        stallE;
    logic [31:0] mfResultE;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic        divZeroE;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .multE     (multE),
        .divE      (divE),
        .mfE       (mfE),
        .srcAE     (srcAE),
        .srcBE     (srcBE),
        .busyE     (busyE),
        .stallE    (stallE),
        .mfResultE (mfResultE),
        .hiE       (hiE),
        .loE       (loE),
        .divZeroE  (divZeroE)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: returns {hi, lo} from signed arithmetic.
    function automatic logic [63:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Driver: present a request for one cycle and queue its expected outcome.
    task automatic issue(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        logic [7:0]  lat;
        logic [1:0]  dz;
        res = model(is_mul, a, b);
        lat = is_mul ? 8'(MUL_LAT) : 8'(DIV_LAT);
        dz  = (!is_mul && b == 32'd0) ? 2'd1 : 2'd0;
        @(posedge clk); #2;
        multE = is_mul;
        divE  = !is_mul;
        srcAE = a;
        srcBE = b;
        exp_q.push_back({lat, dz, res});
        last_hi = res[63:32];
        last_lo = res[31:0];
        @(posedge clk); #2;
        multE = 1'b0;
        divE  = 1'b0;
        srcAE = $urandom;
        srcBE = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busyE !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busyE !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: busyE still %b after %0d cycles (want 0)", busyE, n);
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'd1;
            4: begin
                v = 32'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: count busy cycles and divZeroE pulses per operation, compare
    // on the busy-to-idle transition against the queued expectation.
    initial begin
        bit prev_busy = 1'b0;
        int busy_cnt = 0;
        int dz_cnt = 0;
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_busy = 1'b0;
                busy_cnt = 0;
                dz_cnt = 0;
            end else begin
                if (busyE === 1'b1) begin
                    busy_cnt++;
                    if (divZeroE === 1'b1) dz_cnt++;
                end else begin
                    if (divZeroE !== 1'b0) check("divzero_idle", 64'(divZeroE), 64'd0);
                    if (prev_busy) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done: completion with empty queue hi=0x%0h lo=0x%0h", hiE, loE);
                        end else begin
                            e = exp_q.pop_front();
                            check("sb_hi", 64'(hiE), 64'(e[63:32]));
                            check("sb_lo", 64'(loE), 64'(e[31:0]));
                            check("sb_latency", 64'(busy_cnt), 64'(e[73:66]));
                            check("sb_divzero_pulses", 64'(dz_cnt), 64'(e[65:64]));
                        end
                    end
                    busy_cnt = 0;
                    dz_cnt = 0;
                end
                prev_busy = (busyE === 1'b1);
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busyE), 64'd0);
        check("rst_hi", 64'(hiE), 64'd0);
        check("rst_lo", 64'(loE), 64'd0);
        check("rst_divzero", 64'(divZeroE), 64'd0);
        check("rst_stall", 64'(stallE), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // MULT 7 x -3
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        check("mult_7x-3_lo", 64'(loE), 64'hFFFF_FFEB);
        check("mult_7x-3_hi", 64'(hiE), 64'hFFFF_FFFF);

        // DIV -7 / 2
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_-7/2_lo", 64'(loE), 64'hFFFF_FFFD);
        check("div_-7/2_hi", 64'(hiE), 64'hFFFF_FFFF);

        // DIV 5 / 0
        issue(1'b0, 32'd5, 32'd0);
        wait_idle();
        check("div_5/0_lo", 64'(loE), 64'hFFFF_FFFF);
        check("div_5/0_hi", 64'(hiE), 64'd5);

        // MFHI three cycles after a MULT start: stall until idle, then read HI
        issue(1'b1, 32'h1234_5678, 32'hFFFF_F000);
        @(posedge clk);
        @(posedge clk); #2;
        mfE = 2'b01;
        n = 0;
        @(negedge clk);
        while (busyE === 1'b1 && n < 100) begin
            check("mfhi_stall_busy", 64'(stallE), 64'd1);
            @(negedge clk);
            n++;
        end
        check("mfhi_busy_done", 64'(busyE), 64'd0);
        check("mfhi_stall_idle", 64'(stallE), 64'd0);
        check("mfhi_result", 64'(mfResultE), 64'(last_hi));
        @(posedge clk); #2;
        mfE = 2'b10;
        #1;
        check("mflo_result", 64'(mfResultE), 64'(last_lo));
        mfE = 2'b11;
        #1;
        check("mf_none_result", 64'(mfResultE), 64'd0);
        mfE = 2'b00;

        // New requests while busy are ignored
        issue(1'b1, 32'd1000, 32'd3000);
        repeat (4) @(posedge clk);
        #2;
        divE = 1'b1;
        srcAE = 32'd99;
        srcBE = 32'd7;
        #1;
        check("busy_req_stall", 64'(stallE), 64'd1);
        @(posedge clk); #2;
        divE = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_req_no_queue", 64'(busyE), 64'd0);
        check("busy_req_result", 64'(loE), 64'd3000000);

        // Reset at DIV iteration 10
        issue(1'b0, 32'h7654_3210, 32'd13);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busyE), 64'd0);
        check("midrst_hi", 64'(hiE), 64'd0);
        check("midrst_lo", 64'(loE), 64'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("div_min/-1_lo", 64'(loE), 64'h8000_0000);
        check("div_min/-1_hi", 64'(hiE), 64'd0);

        // MULT 0x10000 x 0x10000
        issue(1'b1, 32'h0001_0000, 32'h0001_0000);
        wait_idle();
        check("mult_2^32_hi", 64'(hiE), 64'd1);
        check("mult_2^32_lo", 64'(loE), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 1) == 1, rand_opnd(), rand_opnd());
            wait_idle();
        end

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have the port multE, input, 1 bit: execute-stage signed MULT request.
REQ-004 SHALL have the port divE, input, 1 bit: execute-stage signed DIV request.
REQ-005 SHALL have the port mfE, input, 2 bits: 2'b01 = MFHI, 2'b10 = MFLO, other values = no move.
REQ-006 SHALL have the ports srcAE and srcBE, input, 32 bits each: forwarded rs/rt operands.
REQ-007 SHALL have the port busyE, output, 1 bit: high when the state is not IDLE.
REQ-008 SHALL have the port stallE, output, 1 bit: request to the hazard unit to freeze F/D/E.
REQ-009 SHALL have the port mfResultE, output, 32 bits: HI when mfE = 01, LO when mfE = 10, 0 otherwise.
REQ-010 SHALL have the ports hiE and loE, output, 32 bits each: architectural HI/LO registers.
REQ-011 SHALL have the port divZeroE, output, 1 bit: one-cycle pulse on completion of a divide by zero.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV and FIX.
REQ-013 SHALL, in IDLE, start an operation when multE or divE is high: capture |srcAE|, |srcBE| and the sign flags, clear the iteration counter, and go to MUL or DIV.
REQ-014 SHALL give multE priority when multE and divE are both high.
REQ-015 SHALL perform a 32-iteration unsigned shift-add multiply in MUL (one iteration per cycle), then go to FIX.
REQ-016 SHALL perform a 32-iteration restoring divide in DIV (one iteration per cycle), then go to FIX.
REQ-017 SHALL apply signs in FIX:
  - product negated if the operand signs differ;
  - quotient negated if the operand signs differ;
  - remainder takes the sign of the dividend.
REQ-018 SHALL write HI/LO in FIX and return to IDLE; HI/LO are visible 33 cycles after the start edge.
REQ-019 SHALL, for a divisor of 0, set LO = 0xFFFFFFFF and HI = the dividend, pulse divZeroE in FIX, and take the same 33-cycle latency.
REQ-020 SHALL produce LO = 0x80000000 and HI = 0 for 0x80000000 / -1, with no trap.
REQ-021 SHALL drive stallE = (state != IDLE) && (multE || divE || mfE != 0).
REQ-022 SHALL ignore new multE/divE while the state is not IDLE; there is no queueing.
REQ-023 SHALL NOT abort a running operation on a pipeline flush; only reset aborts.
REQ-024 SHALL drive mfResultE combinationally from the HI/LO registers; a read is valid only when stallE is low.

Reset
REQ-025 SHALL, on rst_n low and asynchronously, force state = IDLE, hiE = loE = 0, the counter and datapath registers = 0, and divZeroE = 0.
REQ-026 SHALL, on reset mid-operation, discard the operation and leave HI/LO at 0 with busyE low immediately.

Configuration
REQ-027 SHALL use the macro MULDIV_FAST_MUL_EN: when defined, MUL computes the full 64-bit magnitude product in one cycle, so HI/LO are visible 2 cycles after start.
REQ-028 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiply of REQ-015; DIV is iterative in both builds.

Structure
REQ-029 SHALL place the following in package muldiv_pkg: the state encoding, the mfE codes (MF_NONE, MF_HI, MF_LO), and MULDIV_ITER = 32.
REQ-030 SHALL implement one restoring-divide iteration as the combinational sub-module muldiv_divstep, with inputs partial remainder, quotient and divisor, and outputs the next remainder and quotient.

Verification
REQ-031 SHALL cover: MULT 7 x -3 -> busyE high 33 cycles; then LO = 0xFFFFFFEB, HI = 0xFFFFFFFF.
REQ-032 SHALL cover: DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 33 cycles.
REQ-033 SHALL cover: DIV 5 / 0 -> LO = 0xFFFFFFFF, HI = 5, divZeroE high for exactly 1 cycle.
REQ-034 SHALL cover: MFHI presented 3 cycles after a MULT start -> stallE high until IDLE; then mfResultE = the new HI.
REQ-035 SHALL cover: rst_n low at DIV iteration 10 -> IDLE, HI = LO = 0, busyE = 0 with no clock edge; then DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
REQ-036 SHALL cover, with MULDIV_FAST_MUL_EN defined: MULT 0x10000 x 0x10000 -> HI = 1, LO = 0, 2 cycles after start.
